// File: rtl/avl_ram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : i_avl_bus
//  Description : Avalon-style memory-mapped bus with burst support. The
//                initiator drives address, byte_en, read, write, write_data,
//                begin_burst_transfer, burst_count and resp_ready; the
//                responder returns read_data, read_data_valid and
//                request_ready.
//  Modports    : master - initiator end
//                slave  - responder end
//  Revision    : 1.0 - initial release
// ============================================================================
interface i_avl_bus #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BURST_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   write_data;
    logic                    begin_burst_transfer;
    logic [BURST_WIDTH-1:0]  burst_count;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    read_data_valid;
    logic                    request_ready;

    modport master (
        output address, byte_en, read, write, write_data,
               begin_burst_transfer, burst_count, resp_ready,
        input  read_data, read_data_valid, request_ready
    );

    modport slave (
        input  address, byte_en, read, write, write_data,
               begin_burst_transfer, burst_count, resp_ready,
        output read_data, read_data_valid, request_ready
    );
endinterface
`default_nettype wire

// File: rtl/avl_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : avl_ram_slave
//  Description : Burst-capable RAM responder on an Avalon-style bus. Holds
//                DEPTH words of DATA_WIDTH bits with byte-lane writes. Write
//                bursts are absorbed at the bus rate (stalls via write=0);
//                read bursts stream beats with resp_ready back-pressure.
//  Ports       : clk    - single clock, rising edge
//                rst    - synchronous active-high reset
//                avl_in - slave modport of i_avl_bus
//  Revision    : 1.0 - initial release
// ============================================================================
module avl_ram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BURST_WIDTH = 8,
    parameter int DEPTH       = 256
) (
    input  logic     clk,
    input  logic     rst,
    i_avl_bus.slave  avl_in
);

    localparam int c_nb   = DATA_WIDTH / 8;
    localparam int c_alsb = $clog2(c_nb);
    localparam int c_iw   = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_iw-1:0]         r_ptr;
    logic [BURST_WIDTH-1:0]  r_remaining;
    logic                    r_rd_wait;
    logic                    r_req_ready;
    logic                    r_rdv;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [c_iw-1:0]         w_index;
    logic [BURST_WIDTH-1:0]  w_len;
    logic [c_iw-1:0]         w_waddr;
    logic                    w_we;
    logic                    w_rd_load;
    logic                    w_rd_done;
    logic [ADDR_WIDTH-1:0]   w_unused_addr;

    // Only the word-index slice of the address is decoded.
    assign w_unused_addr = avl_in.address;
    assign w_index       = avl_in.address[c_alsb +: c_iw];

    // burst_count of zero is treated as a single beat.
    assign w_len = (avl_in.begin_burst_transfer && (avl_in.burst_count != '0))
                 ? avl_in.burst_count : BURST_WIDTH'(1);

    // request_ready is only high in IDLE/WR_BURST, so it doubles as the
    // "writes may be accepted" qualifier.
    assign w_we    = ~rst & r_req_ready & avl_in.write;
    assign w_waddr = (r_state == WR_BURST) ? r_ptr : w_index;

    // r_rd_wait inserts the one-cycle gap that places the first beat two
    // edges after acceptance.
    assign w_rd_load = (r_state == RD_BURST) & ~r_rd_wait
                     & (~r_rdv | avl_in.resp_ready)
                     & (r_remaining != '0);
    assign w_rd_done = (r_state == RD_BURST) & r_rdv & avl_in.resp_ready
                     & (r_remaining == '0);

    // Storage: no reset, byte-lane write enables.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < c_nb; b++) begin
                if (avl_in.byte_en[b]) begin
                    r_mem[w_waddr][b*8 +: 8] <= avl_in.write_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_rd_wait   <= 1'b0;
            r_req_ready <= 1'b0;
            r_rdv       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    r_rd_wait   <= 1'b0;
                    if (r_req_ready && avl_in.write) begin
                        // Write wins over a simultaneous read.
                        if (w_len != BURST_WIDTH'(1)) begin
                            r_state     <= WR_BURST;
                            r_ptr       <= w_index + c_iw'(1);
                            r_remaining <= w_len - BURST_WIDTH'(1);
                        end
                    end else if (r_req_ready && avl_in.read) begin
                        r_state     <= RD_BURST;
                        r_ptr       <= w_index;
                        r_remaining <= w_len;
                        r_req_ready <= 1'b0;
                        r_rd_wait   <= 1'b1;
                    end
                end

                WR_BURST: begin
                    r_req_ready <= 1'b1;
                    if (avl_in.write) begin
                        r_ptr <= r_ptr + c_iw'(1);
                        if (r_remaining <= BURST_WIDTH'(1)) begin
                            r_remaining <= '0;
                            r_state     <= IDLE;
                        end else begin
                            r_remaining <= r_remaining - BURST_WIDTH'(1);
                        end
                    end
                end

                RD_BURST: begin
                    r_rd_wait <= 1'b0;
                    if (w_rd_load) begin
                        r_rdata     <= r_mem[r_ptr];
                        r_rdv       <= 1'b1;
                        r_ptr       <= r_ptr + c_iw'(1);
                        r_remaining <= r_remaining - BURST_WIDTH'(1);
                        r_req_ready <= 1'b0;
                    end else if (w_rd_done) begin
                        r_rdv       <= 1'b0;
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_req_ready <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b0;
                    r_rdv       <= 1'b0;
                end
            endcase
        end
    end

    assign avl_in.request_ready   = r_req_ready;
    assign avl_in.read_data_valid = r_rdv;
    assign avl_in.read_data       = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_avl_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avl_ram_slave
//  Description : Self-checking bench for avl_ram_slave. A transaction-level
//                model (word array plus expected-beat queue) is stepped once
//                per cycle and compared against the DUT outputs; directed
//                scenarios pin the model with literal values, then a random
//                mix of bursts runs against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avl_ram_slave;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i_avl_bus #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_WIDTH(8)) bus ();

    avl_ram_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BURST_WIDTH(8),
        .DEPTH      (256)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .avl_in(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] ref_mem [256];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    bit          busy_rd   = 1'b0;
    int          k         = 0;
    bit          ready_exp = 1'b0;
    int          wr_left   = 0;
    int          wr_ptr    = 0;
    bit          started   = 1'b0;
    bit          prev_rdv  = 1'b0;
    bit          prev_rr   = 1'b0;
    logic [31:0] prev_data = '0;

    // Stimulus buffers
    logic [31:0] wbuf [256];
    logic [3:0]  wbe  [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic int blen(input logic bbt, input logic [7:0] bc);
        return (bbt && bc != 8'd0) ? int'(bc) : 1;
    endfunction

    // Compare then step the model for the coming rising edge.
    always @(negedge clk) begin
        int idx;
        int len;
        if (started) begin
            chk("request_ready", 32'(bus.request_ready), 32'(ready_exp));
            chk("read_data_valid", 32'(bus.read_data_valid), 32'(busy_rd && k >= 2));
            if (bus.read_data_valid && prev_rdv && !prev_rr)
                chk("stall_hold", bus.read_data, prev_data);
            if (bus.read_data_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=no_beat t=%0t",
                             bus.read_data, $time);
                end else begin
                    chk("beat_data", bus.read_data, exp_q[0]);
                end
                got_q.push_back(bus.read_data);
            end
        end

        if (rst) begin
            busy_rd   = 1'b0;
            exp_q.delete();
            wr_left   = 0;
            ready_exp = 1'b0;
        end else if (busy_rd) begin
            k++;
            if (bus.read_data_valid && bus.resp_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) busy_rd = 1'b0;
            end
            ready_exp = !busy_rd;
        end else begin
            if (ready_exp) begin
                idx = int'(bus.address[9:2]);
                len = blen(bus.begin_burst_transfer, bus.burst_count);
                if (wr_left > 0) begin
                    if (bus.write) begin
                        ref_mem[wr_ptr] = merge(ref_mem[wr_ptr], bus.write_data, bus.byte_en);
                        wr_ptr  = (wr_ptr + 1) % 256;
                        wr_left--;
                    end
                end else if (bus.write) begin
                    ref_mem[idx] = merge(ref_mem[idx], bus.write_data, bus.byte_en);
                    wr_left = len - 1;
                    wr_ptr  = (idx + 1) % 256;
                end else if (bus.read) begin
                    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(idx + i) % 256]);
                    busy_rd = 1'b1;
                    k       = 0;
                end
            end
            ready_exp = !busy_rd;
        end
        prev_rdv  = bus.read_data_valid;
        prev_rr   = bus.resp_ready;
        prev_data = bus.read_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.address              = '0;
        bus.byte_en              = '0;
        bus.read                 = 1'b0;
        bus.write                = 1'b0;
        bus.write_data           = '0;
        bus.begin_burst_transfer = 1'b0;
        bus.burst_count          = '0;
    endtask

    // Issue a write (burst) using wbuf/wbe; stalls and stray reads are
    // sprinkled between burst beats.
    task automatic do_write(input logic [31:0] addr, input logic bbt,
                            input logic [7:0] bc, input logic both);
        int len;
        len = blen(bbt, bc);
        bus.address              = addr;
        bus.byte_en              = wbe[0];
        bus.write                = 1'b1;
        bus.read                 = both;
        bus.write_data           = wbuf[0];
        bus.begin_burst_transfer = bbt;
        bus.burst_count          = bc;
        step();
        for (int i = 1; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.write   = 1'b0;
                bus.read    = 1'($urandom_range(0, 1));
                bus.address = $urandom;
                step();
            end
            bus.write                = 1'b1;
            bus.read                 = 1'b0;
            bus.address              = $urandom;
            bus.begin_burst_transfer = 1'($urandom_range(0, 1));
            bus.write_data           = wbuf[i];
            bus.byte_en              = wbe[i];
            step();
        end
        bus_idle();
    endtask

    // mode 0: resp_ready always 1; 1: pattern 1,0,0 repeating; 2: random.
    task automatic do_read(input logic [31:0] addr, input logic bbt,
                           input logic [7:0] bc, input int mode);
        bus.address              = addr;
        bus.read                 = 1'b1;
        bus.write                = 1'b0;
        bus.begin_burst_transfer = bbt;
        bus.burst_count          = bc;
        bus.resp_ready           = 1'b1;
        step();
        bus_idle();
        for (int c = 0; c < 2000; c++) begin
            if (!busy_rd) break;
            case (mode)
                0:       bus.resp_ready = 1'b1;
                1:       bus.resp_ready = ((c % 3) == 0);
                default: bus.resp_ready = 1'($urandom_range(0, 1));
            endcase
            step();
        end
        if (busy_rd) begin
            checks++;
            errors++;
            $display("FAIL read_timeout actual=busy required=idle t=%0t", $time);
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus_idle();
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (2) step();
        chk("rst_request_ready", 32'(bus.request_ready), 32'd0);
        chk("rst_rdv", 32'(bus.read_data_valid), 32'd0);
        chk("rst_read_data", bus.read_data, 32'd0);
        started = 1'b1;
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(bus.request_ready), 32'd1);

        // Fill all of memory with known contents (two 128-beat bursts).
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 128; i++) begin
                wbuf[i] = $urandom;
                wbe[i]  = 4'hF;
            end
            do_write(32'(h * 512), 1'b1, 8'd128, 1'b0);
        end

        // Byte-lane merge then single read.
        wbuf[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
        do_write(32'h10, 1'b0, 8'd0, 1'b0);
        wbuf[0] = 32'h000000AA; wbe[0] = 4'h1;
        do_write(32'h10, 1'b0, 8'd0, 1'b0);
        got_q.delete();
        do_read(32'h10, 1'b0, 8'd0, 0);
        chk("merge_beats", 32'(got_q.size()), 32'd1);
        chk("merge_data", got_q[0], 32'hDEADBEAA);

        // Wrapping write and read bursts.
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'hA0A0A0A0 + 32'(i);
            wbe[i]  = 4'hF;
        end
        do_write(32'h3F8, 1'b1, 8'd4, 1'b0);
        got_q.delete();
        do_read(32'h3F8, 1'b1, 8'd4, 0);
        chk("wrap_beats", 32'(got_q.size()), 32'd4);
        chk("wrap_w254", got_q[0], 32'hA0A0A0A0);
        chk("wrap_w255", got_q[1], 32'hA0A0A0A1);
        chk("wrap_w0", got_q[2], 32'hA0A0A0A2);
        chk("wrap_w1", got_q[3], 32'hA0A0A0A3);
        got_q.delete();
        do_read(32'h0, 1'b0, 8'd0, 0);
        chk("wrap_word0_direct", got_q[0], 32'hA0A0A0A2);

        // 8-beat read with 1,0,0 back-pressure.
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'hC0DE0000 + 32'(i);
            wbe[i]  = 4'hF;
        end
        do_write(32'h40, 1'b1, 8'd8, 1'b0);
        got_q.delete();
        do_read(32'h40, 1'b1, 8'd8, 1);
        chk("bp_beats", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("bp_data", got_q[i], 32'hC0DE0000 + 32'(i));

        // burst_count=0 with begin, and burst_count=5 without begin: single beats.
        wbe[0] = 4'hF;
        wbuf[0] = 32'h11111111;
        do_write(32'h54, 1'b0, 8'd0, 1'b0);
        do_write(32'h7C, 1'b0, 8'd0, 1'b0);
        wbuf[0] = 32'h22222222;
        do_write(32'h50, 1'b1, 8'd0, 1'b0);
        wbuf[0] = 32'h33333333;
        do_write(32'h78, 1'b0, 8'd5, 1'b0);
        got_q.delete();
        do_read(32'h50, 1'b1, 8'd2, 0);
        chk("bc0_w20", got_q[0], 32'h22222222);
        chk("bc0_w21", got_q[1], 32'h11111111);
        got_q.delete();
        do_read(32'h78, 1'b1, 8'd2, 0);
        chk("nobbt_w30", got_q[0], 32'h33333333);
        chk("nobbt_w31", got_q[1], 32'h11111111);
        got_q.delete();
        do_read(32'h50, 1'b1, 8'd0, 0);
        chk("bc0_read_beats", 32'(got_q.size()), 32'd1);
        got_q.delete();
        do_read(32'h78, 1'b0, 8'd5, 0);
        chk("nobbt_read_beats", 32'(got_q.size()), 32'd1);

        // Reset during beat 3 of a 6-beat read.
        for (int i = 0; i < 6; i++) begin
            wbuf[i] = 32'h60000000 + 32'(i);
            wbe[i]  = 4'hF;
        end
        do_write(32'h100, 1'b1, 8'd6, 1'b0);
        got_q.delete();
        bus.address              = 32'h100;
        bus.read                 = 1'b1;
        bus.begin_burst_transfer = 1'b1;
        bus.burst_count          = 8'd6;
        bus.resp_ready           = 1'b1;
        step();
        bus_idle();
        for (int c = 0; c < 50; c++) begin
            if (got_q.size() >= 2) break;
            step();
        end
        chk("rst_mid_beats_before", 32'(got_q.size()), 32'd2);
        rst = 1'b1;
        bus.resp_ready = 1'b0;
        step();
        chk("rst_mid_rdv", 32'(bus.read_data_valid), 32'd0);
        chk("rst_mid_ready", 32'(bus.request_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_mid_ready_after", 32'(bus.request_ready), 32'd1);
        wbuf[0] = 32'h77777777; wbe[0] = 4'hF;
        do_write(32'h118, 1'b0, 8'd0, 1'b0);
        got_q.delete();
        do_read(32'h118, 1'b0, 8'd0, 0);
        chk("rst_mid_readback", got_q[0], 32'h77777777);

        // read and write together in IDLE: write only.
        wbuf[0] = 32'h34343434; wbe[0] = 4'hF;
        got_q.delete();
        do_write(32'h200, 1'b0, 8'd0, 1'b1);
        repeat (6) step();
        chk("rw_no_beat", 32'(got_q.size()), 32'd0);
        do_read(32'h200, 1'b0, 8'd0, 0);
        chk("rw_write_data", got_q[0], 32'h34343434);

        // Random mix.
        for (int t = 0; t < 80; t++) begin
            logic [7:0] bc;
            logic       bbt;
            bc  = 8'($urandom_range(0, 12));
            bbt = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wbuf[i] = $urandom;
                    wbe[i]  = 4'($urandom);
                end
                do_write($urandom, bbt, bc, 1'($urandom_range(0, 1)));
            end else begin
                do_read($urandom, bbt, bc, int'($urandom_range(0, 2)));
            end
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avl_ram_slave.md
AVL_RAM_SLAVE -- requirements
Module: avl_ram_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width in bits, a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 Parameter BURST_WIDTH, default 8: burst_count width.
REQ-004 Parameter DEPTH, default 256: memory depth in words, a power of 2.
REQ-005 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port avl_in, i_avl_bus.slave modport: responder end of the bus; request fields from the initiator are address, byte_en, read, write, write_data, begin_burst_transfer, burst_count and resp_ready; responses to the initiator are read_data, read_data_valid and request_ready.

Function
REQ-008 The block SHALL hold DEPTH words of DATA_WIDTH bits in internal storage, with word index = address[ALSB +: log2(DEPTH)] and ALSB = log2(DATA_WIDTH/8); upper address bits are ignored.
REQ-009 The FSM SHALL have exactly three states: IDLE, WR_BURST and RD_BURST.
REQ-010 A request SHALL be accepted only in a cycle where request_ready=1 and (read or write)=1.
REQ-011 Burst length L SHALL be max(burst_count,1) when begin_burst_transfer=1 at acceptance, and 1 otherwise; burst_count=0 is treated as 1.
REQ-012 request_ready SHALL be 1 in IDLE and WR_BURST, and 0 in RD_BURST.
REQ-013 In IDLE, when write and read are both 1, the request SHALL be treated as a write and the read ignored.
REQ-014 Each accepted write beat SHALL update the addressed word in the same cycle, writing only the byte lanes whose byte_en bit is 1; other lanes keep their old value.
REQ-015 Write, IDLE with L=1: the single beat SHALL be written and the FSM SHALL stay in IDLE.
REQ-016 Write, IDLE with L>1: the FSM SHALL go to WR_BURST, with pointer = index+1 and remaining = L-1.
REQ-017 In WR_BURST, each cycle with write=1 SHALL write to the pointer, increment the pointer and decrement remaining; address and begin_burst_transfer are ignored.
REQ-018 The WR_BURST beat that makes remaining 0 SHALL return the FSM to IDLE; cycles with write=0 SHALL stall the burst, and read=1 in WR_BURST SHALL be ignored.
REQ-019 An accepted read SHALL move the FSM to RD_BURST with pointer = index and remaining = L.
REQ-020 In RD_BURST, when (read_data_valid=0 or resp_ready=1) and remaining>0, the block SHALL load read_data with mem[pointer], set read_data_valid=1, increment the pointer and decrement remaining.
REQ-021 The first read beat SHALL appear exactly 2 cycles after the acceptance edge, and back-to-back beats SHALL follow with no bubbles while resp_ready=1.
REQ-022 While read_data_valid=1 and resp_ready=0, read_data and read_data_valid SHALL hold stable.
REQ-023 A beat handshake with resp_ready=1 and remaining=0 SHALL clear read_data_valid and return the FSM to IDLE on the same edge, so request_ready=1 the next cycle.
REQ-024 The pointer SHALL wrap modulo DEPTH (DEPTH-1 -> 0) in both write and read bursts.
REQ-025 The remaining counter SHALL be BURST_WIDTH bits wide and SHALL never underflow.
REQ-026 The read data path SHALL see a write completed on any prior edge; read-during-write collisions cannot occur.

Reset
REQ-027 While rst=1, the block SHALL force state = IDLE, request_ready=0, read_data_valid=0, read_data=0, pointer=0 and remaining=0; request_ready SHALL be 1 in the first cycle after rst=0.
REQ-028 A reset asserted mid-burst SHALL abandon the burst with no further writes or beats; memory contents SHALL NOT be reset.

Verification
REQ-029 Write 0xDEADBEEF to byte address 0x10 with byte_en=0xF, then write 0x000000AA with byte_en=0x1, then read 0x10 -> a single beat of 0xDEADBEAA, 2 cycles after acceptance.
REQ-030 Write burst of 4 words at address 0x3F8 (DEPTH=256) -> words 254, 255, 0 and 1 are written (wrap); a read burst of 4 at 0x3F8 returns the same 4 values in order.
REQ-031 Read burst of 8 with resp_ready toggling 1,0,0,1,... -> exactly 8 beats, each held stable while stalled, in order with no duplicates; request_ready=0 throughout and 1 in the cycle after the final handshake.
REQ-032 burst_count=0 with begin_burst_transfer=1, then begin_burst_transfer=0 with burst_count=5 -> each is a single-beat transfer.
REQ-033 rst=1 during beat 3 of a 6-beat read -> read_data_valid=0 on the next edge and FSM in IDLE; a subsequent write plus read-back behaves normally.
REQ-034 read=1 and write=1 together in IDLE -> a write occurs and no read beat is ever returned.
